sqrt_ctrl: RTL and testbench
============================

# sqrt_ctrl

Sequencing controller for the integer square-root datapath. The datapath performs six bit-iterations per clock, reports `finished`, and holds the result in an output register. This block accepts operands with a valid/ready handshake and drives the datapath's `ld`, `mux_select` and `ld_out` strobes. It presents the result with a valid/ready handshake and reports per-operation iteration count and an optional watchdog error. It sits between the FPU issue logic and the datapath and produces only control signals; `in_num`/`res` connect to the datapath directly.

## Interface
- `SIZE`, 32: datapath operand width; used only to derive `MAX_ITER`.
- `MAX_ITER`, `(SIZE/2+5)/6+1` (=4 for 32): watchdog limit in ITER cycles.
- `CNT_W`, 8: width of `iter_count`.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset; one clock; reset is synchronous and active-low. Shared with the datapath registers.
- `in_valid`  in  1  operand on `in_num` is valid.
- `in_ready`  out  1  controller accepts operand this cycle.
- `finished`  in  1  datapath flag: all bit-iterations complete after the current cycle's six levels.
- `ld`  out  1  datapath working-register load.
- `mux_select`  out  1  1 = load fresh operand, 0 = feed back iteration results.
- `ld_out`  out  1  datapath output-register load.
- `out_valid`  out  1  result (or error) available.
- `out_ready`  in  1  consumer accepts result.
- `busy`  out  1  operation in progress (ITER or STORE).
- `err`  out  1  watchdog fired; qualified by `out_valid`.
- `iter_count`  out  CNT_W  ITER cycles used by the last/current operation.

## Operation
- States: IDLE, ITER, STORE, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: `ld`=1 and `mux_select`=1 (combinational, same cycle); clear `iter_count`; go to ITER.
- ITER:
  - `ld`=1, `mux_select`=0; `iter_count`++ each cycle.
  - If `finished`=1, this load captures the final root; go to STORE.
  - Watchdog: see Configuration.
- STORE: `ld`=0, `ld_out`=1 (copies the final working result to `res`); go to DONE.
- DONE:
  - `out_valid`=1; `ld`, `ld_out` and `mux_select` are 0, so the datapath is frozen.
  - On `out_ready`: go to IDLE.
  - `in_ready`=0 in DONE; no back-to-back overlap.
- `in_valid` outside IDLE is ignored; the operand must be held by the source until accepted.
- `iter_count` saturates at all-ones and is held through DONE; it is cleared only on the next accept.
- `finished` is ignored outside ITER.
- `busy`=1 in ITER and STORE.
- Reset (`rst`=0 at an edge), in any state including mid-ITER: next state IDLE; discard the operation.
  - Reset values: `in_ready`=1 after release; `ld`=`ld_out`=`mux_select`=`out_valid`=`busy`=`err`=0; `iter_count`=0.

## Timing
- Accept at cycle 0 (handshake cycle). ITER runs cycles 1..N, where N = first ITER cycle with `finished`=1. STORE is cycle N+1. `out_valid` rises at cycle N+2, together with a valid `res`.
- N = ceil(P/6), where P = bit-pairs up to the operand's highest set pair. The minimum is N=1 (includes operand 0).
- For SIZE=32 the worst case is N=3, giving a 5-cycle accept-to-valid latency.
- `out_valid` and `err` are registered. `ld`, `mux_select` and `in_ready` are decoded from state plus `in_valid`.
- Throughput: one operation per N+3 cycles with `out_ready` tied high.

## Configuration
- Macro: `SQRT_CTRL_WATCHDOG_EN`.
- Defined:
  - If ITER reaches `iter_count` == `MAX_ITER` with `finished`=0, skip STORE and go straight to DONE with `err`=1; `ld_out` is never pulsed, so `res` keeps its previous value.
  - `err` clears on the DONE→IDLE transition.
- Undefined: no limit; ITER waits indefinitely for `finished`; `err` is tied 0.

## Test plan
- Operand 1024 with datapath attached → `res`=32, `out_valid` at cycle 3 (N=1), `iter_count`=1, `err`=0.
- Operand 0xFFFFFFFF → `res`=65535, `out_valid` at cycle 5, `iter_count`=3, exactly one `ld_out` pulse at cycle 4.
- Operand 0 → `res`=0, N=1. Then hold `out_ready`=0 for 10 cycles → `out_valid` and `res` stable, `in_ready`=0, and a second `in_valid` is ignored until `out_ready`.
- Back-to-back: operands 81 then 144 with `out_ready`=1 → results 9 then 12, second accept exactly one cycle after the first DONE.
- Assert reset mid-ITER (cycle 2 of 0xFFFFFFFF) → next cycle IDLE with all outputs at reset values. Operand 49 then yields 7.
- With `SQRT_CTRL_WATCHDOG_EN`, bench forces `finished`=0 → `out_valid`=1 and `err`=1 at cycle `MAX_ITER`+1 (=5), no `ld_out`, `iter_count`=4. Without the macro, the controller stays in ITER (`busy`=1) for 50 cycles.

Source files
------------

// File: rtl/sqrt_ctrl_if.sv
// sqrt_ctrl_if: handshake and datapath-strobe bundle for the square-root
// sequencing controller. The slave modport is the controller's view; the
// master modport is the surrounding issue logic plus datapath.
interface sqrt_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             finished;
  logic             ld;
  logic             mux_select;
  logic             ld_out;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             err;
  logic [CNT_W-1:0] iter_count;

  modport slave (
    input  in_valid, finished, out_ready,
    output in_ready, ld, mux_select, ld_out, out_valid, busy, err, iter_count
  );

  modport master (
    output in_valid, finished, out_ready,
    input  in_ready, ld, mux_select, ld_out, out_valid, busy, err, iter_count
  );
endinterface

// File: rtl/sqrt_ctrl.sv
// sqrt_ctrl: sequencing controller for the integer square-root datapath.
// Accepts an operand, strobes the datapath until it reports 'finished',
// copies the root into the output register and presents it with valid/ready.
// Optional watchdog: define SQRT_CTRL_WATCHDOG_EN to abort an operation that
// has not finished after MAX_ITER iteration cycles (reported through err).
module sqrt_ctrl #(
  parameter int SIZE     = 32,
  parameter int MAX_ITER = (SIZE/2 + 5)/6 + 1,
  parameter int CNT_W    = 8
) (
  input logic        clk,
  input logic        rst,
  sqrt_ctrl_if.slave bus
);

`ifdef SQRT_CTRL_WATCHDOG_EN
  localparam logic WDOG_EN = 1'b1;
`else
  localparam logic WDOG_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    STORE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] iter_count;
  logic [CNT_W-1:0] iter_next;
  logic             wdog_hit;
  logic             out_valid_q;
  logic             err_q;
  logic             ld_out_q;
  logic             busy_q;

  // Saturating next iteration count, and the watchdog condition it implies.
  always_comb begin
    iter_next = (iter_count == '1) ? iter_count : iter_count + 1'b1;
    wdog_hit  = WDOG_EN && (iter_next == CNT_W'(MAX_ITER)) && !bus.finished;
  end

  // Sequencer: state plus all registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      iter_count  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      ld_out_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            iter_count <= '0;
            busy_q     <= 1'b1;
            state      <= ITER;
          end
        end
        ITER: begin
          iter_count <= iter_next;
          if (bus.finished) begin
            ld_out_q <= 1'b1;
            state    <= STORE;
          end else if (wdog_hit) begin
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            err_q       <= 1'b1;
            state       <= DONE;
          end
        end
        STORE: begin
          ld_out_q    <= 1'b0;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath load strobes and input ready are decoded so the accept cycle loads at once.
  always_comb begin
    bus.in_ready   = (state == IDLE);
    bus.ld         = ((state == IDLE) && bus.in_valid) || (state == ITER);
    bus.mux_select = (state == IDLE) && bus.in_valid;
  end

  assign bus.ld_out     = ld_out_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.busy       = busy_q;
  assign bus.err        = err_q;
  assign bus.iter_count = iter_count;

endmodule

// File: tb/tb_sqrt_ctrl.sv
// tb_sqrt_ctrl: self-checking bench for sqrt_ctrl with a behavioural
// datapath attached and a reference model of latency, iteration count and root.
module tb_sqrt_ctrl;

  localparam int MAX_ITER = (32/2 + 5)/6 + 1;

  logic        clk;
  logic        rst;
  logic [31:0] in_num;
  logic [31:0] op_q;
  logic [31:0] wr;
  logic [31:0] res;
  int          dp_iter;
  int          dp_n;
  logic        force_unfinished;

  int n_compared;
  int n_mismatched;

  sqrt_ctrl_if #(.CNT_W(8)) bus ();

  sqrt_ctrl #(.SIZE(32), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference root: largest r with r*r <= x.
  function automatic logic [31:0] ref_isqrt(input logic [31:0] x);
    longint r;
    longint t;
    r = 0;
    for (int b = 15; b >= 0; b--) begin
      t = r + (longint'(1) << b);
      if (t * t <= longint'(x)) r = t;
    end
    return 32'(r);
  endfunction

  // Reference iteration count: ceil(pairs/6), at least 1.
  function automatic int ref_n(input logic [31:0] x);
    int p;
    int n;
    p = 0;
    for (int i = 0; i < 16; i++) if (x[2*i +: 2] != 2'b00) p = i + 1;
    n = (p + 5) / 6;
    return (n < 1) ? 1 : n;
  endfunction

  // Behavioural datapath: six levels per cycle, final root captured on the last load.
  assign bus.finished = !force_unfinished && (dp_iter + 1 >= dp_n);

  always @(posedge clk) begin
    if (!rst) begin
      dp_iter <= 0;
      dp_n    <= 1;
      wr      <= '0;
      res     <= '0;
      op_q    <= '0;
    end else begin
      if (bus.ld && bus.mux_select) begin
        dp_iter <= 0;
        dp_n    <= ref_n(in_num);
        op_q    <= in_num;
        wr      <= '0;
      end else if (bus.ld) begin
        dp_iter <= dp_iter + 1;
        if (bus.finished) wr <= ref_isqrt(op_q);
      end
      if (bus.ld_out) res <= wr;
    end
  end

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_compared++;
    if ({bus.in_ready, bus.ld, bus.ld_out, bus.mux_select, bus.out_valid, bus.busy, bus.err} !== 7'b1000000) begin
      n_mismatched++;
      $display("[TB] FAIL reset_outputs: got %b expected %b", {bus.in_ready, bus.ld, bus.ld_out, bus.mux_select, bus.out_valid, bus.busy, bus.err}, 7'b1000000);
    end
    n_compared++;
    if (bus.iter_count !== 8'd0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_iter_count: got %0d expected 0", bus.iter_count);
    end
    rst = 1'b1;
  endtask

  // One operation; result held for 'hold' cycles with a stray in_valid, then consumed.
  task automatic run_op(input string name, input logic [31:0] op, input int hold);
    int          n;
    int          cyc;
    int          ov_cyc;
    int          ldout_cnt;
    int          ldout_cyc;
    logic        busy_ok;
    logic        hold_ok;
    logic [31:0] exp_res;
    logic [31:0] res_seen;
    n       = ref_n(op);
    exp_res = ref_isqrt(op);
    @(negedge clk);
    in_num        = op;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    #1;
    n_compared++;
    if ({bus.in_ready, bus.ld, bus.mux_select} !== 3'b111) begin
      n_mismatched++;
      $display("[TB] FAIL %s accept_strobes: got %b expected 111", name, {bus.in_ready, bus.ld, bus.mux_select});
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    in_num       = $urandom;
    cyc = 1; ov_cyc = -1; ldout_cnt = 0; ldout_cyc = -1; busy_ok = 1'b1;
    while (cyc <= 40) begin
      if (bus.out_valid) begin
        ov_cyc = cyc;
        break;
      end
      if (bus.ld_out) begin
        ldout_cnt++;
        ldout_cyc = cyc;
      end
      if (!bus.busy) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    n_compared++;
    if (ov_cyc != n + 2) begin
      n_mismatched++;
      $display("[TB] FAIL %s latency: got %0d expected %0d", name, ov_cyc, n + 2);
    end
    n_compared++;
    if (bus.iter_count !== 8'(n)) begin
      n_mismatched++;
      $display("[TB] FAIL %s iter_count: got %0d expected %0d", name, bus.iter_count, n);
    end
    n_compared++;
    if (ldout_cnt != 1 || ldout_cyc != n + 1) begin
      n_mismatched++;
      $display("[TB] FAIL %s ld_out: got %0d pulses at %0d expected 1 at %0d", name, ldout_cnt, ldout_cyc, n + 1);
    end
    n_compared++;
    if (bus.err !== 1'b0 || busy_ok !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL %s err_busy: got err=%b busy_ok=%b expected err=0 busy_ok=1", name, bus.err, busy_ok);
    end
    n_compared++;
    if (res !== exp_res) begin
      n_mismatched++;
      $display("[TB] FAIL %s res: got %0d expected %0d", name, res, exp_res);
    end
    res_seen = res;
    hold_ok  = 1'b1;
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      in_num       = $urandom;
      #1;
      if (!bus.out_valid || bus.in_ready || bus.ld || bus.ld_out || res !== res_seen) hold_ok = 1'b0;
      @(negedge clk);
    end
    if (hold > 0) begin
      n_compared++;
      if (hold_ok !== 1'b1) begin
        n_mismatched++;
        $display("[TB] FAIL %s hold_stable: got %b expected 1", name, hold_ok);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_compared++;
    if ({bus.out_valid, bus.in_ready, bus.err} !== 3'b010 || bus.iter_count !== 8'(n) || res !== exp_res) begin
      n_mismatched++;
      $display("[TB] FAIL %s release: got ov/ir/err=%b cnt=%0d res=%0d expected 010 cnt=%0d res=%0d", name, {bus.out_valid, bus.in_ready, bus.err}, bus.iter_count, res, n, exp_res);
    end
  endtask

  task automatic test_back_to_back();
    int          acc_c [2];
    logic [31:0] got [2];
    int          nacc;
    int          nres;
    nacc = 0; nres = 0;
    acc_c[0] = -100; acc_c[1] = -100; got[0] = '1; got[1] = '1;
    @(negedge clk);
    in_num        = 32'd81;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && nres < 2; cyc++) begin
      #1;
      if (bus.out_valid) begin
        got[nres] = res;
        nres++;
      end
      if (bus.in_valid && bus.in_ready && nacc < 2) begin
        acc_c[nacc] = cyc;
        nacc++;
      end
      @(negedge clk);
      if (nacc == 1) in_num = 32'd144;
      if (nacc == 2) bus.in_valid = 1'b0;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    n_compared++;
    if (acc_c[1] - acc_c[0] != ref_n(32'd81) + 3) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_accept_gap: got %0d expected %0d", acc_c[1] - acc_c[0], ref_n(32'd81) + 3);
    end
    n_compared++;
    if (got[0] !== 32'd9 || got[1] !== 32'd12) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_results: got %0d,%0d expected 9,12", got[0], got[1]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_iter();
    @(negedge clk);
    in_num       = 32'hFFFF_FFFF;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_compared++;
    if ({bus.in_ready, bus.ld, bus.ld_out, bus.mux_select, bus.out_valid, bus.busy, bus.err} !== 7'b1000000 || bus.iter_count !== 8'd0) begin
      n_mismatched++;
      $display("[TB] FAIL mid_iter_reset: got %b cnt=%0d expected 1000000 cnt=0", {bus.in_ready, bus.ld, bus.ld_out, bus.mux_select, bus.out_valid, bus.busy, bus.err}, bus.iter_count);
    end
    rst = 1'b1;
    run_op("after_reset_49", 32'd49, 0);
  endtask

  task automatic test_watchdog();
    logic [31:0] res_before;
    int          cyc;
    int          ov_cyc;
    int          ldout_cnt;
    logic        stuck_ok;
    force_unfinished = 1'b1;
    res_before       = res;
    @(negedge clk);
    in_num       = 32'hFFFF_FFFF;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
`ifdef SQRT_CTRL_WATCHDOG_EN
    cyc = 1; ov_cyc = -1; ldout_cnt = 0; stuck_ok = 1'b1;
    while (cyc <= 40) begin
      if (bus.out_valid) begin
        ov_cyc = cyc;
        break;
      end
      if (bus.ld_out) ldout_cnt++;
      @(negedge clk);
      cyc++;
    end
    n_compared++;
    if (ov_cyc != MAX_ITER + 1 || bus.err !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL wdog_fire: got cycle %0d err=%b expected cycle %0d err=1", ov_cyc, bus.err, MAX_ITER + 1);
    end
    n_compared++;
    if (ldout_cnt != 0 || bus.iter_count !== 8'(MAX_ITER) || res !== res_before) begin
      n_mismatched++;
      $display("[TB] FAIL wdog_state: got ld_out=%0d cnt=%0d res=%0d expected 0 cnt=%0d res=%0d", ldout_cnt, bus.iter_count, res, MAX_ITER, res_before);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_compared++;
    if ({bus.out_valid, bus.err, bus.in_ready} !== 3'b001) begin
      n_mismatched++;
      $display("[TB] FAIL wdog_clear: got %b expected 001", {bus.out_valid, bus.err, bus.in_ready});
    end
`else
    stuck_ok = 1'b1; ov_cyc = -1; ldout_cnt = 0; cyc = 0;
    for (int c = 0; c < 50; c++) begin
      if (!bus.busy || bus.out_valid || bus.ld_out || bus.err || !bus.ld) stuck_ok = 1'b0;
      @(negedge clk);
    end
    n_compared++;
    if (stuck_ok !== 1'b1 || res !== res_before) begin
      n_mismatched++;
      $display("[TB] FAIL no_wdog_stuck: got %b res=%0d expected 1 res=%0d", stuck_ok, res, res_before);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    n_compared++;
    if ({bus.busy, bus.in_ready} !== 2'b01) begin
      n_mismatched++;
      $display("[TB] FAIL no_wdog_recover: got %b expected 01", {bus.busy, bus.in_ready});
    end
`endif
    force_unfinished = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] op;
    for (int i = 0; i < 12; i++) begin
      op = $urandom >> $urandom_range(0, 31);
      run_op($sformatf("rand%0d", i), op, $urandom_range(0, 3));
    end
  endtask

  initial begin
    n_compared       = 0;
    n_mismatched     = 0;
    rst              = 1'b0;
    force_unfinished = 1'b0;
    in_num           = '0;
    bus.in_valid     = 1'b0;
    bus.out_ready    = 1'b0;
    test_reset();
    run_op("op_1024", 32'd1024, 0);
    run_op("op_max", 32'hFFFF_FFFF, 0);
    run_op("op_zero_hold", 32'd0, 10);
    test_back_to_back();
    test_reset_mid_iter();
    test_watchdog();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
